// File: rtl/clut_pkg.sv
// Shared constants for the clutter-map read/write controller and its bench.
package clut_pkg;

   // Default geometry: 4096 cells per frame, 16-bit magnitudes.
   localparam int ADDR_W_DEF     = 12;
   localparam int DATA_W_DEF     = 16;
   localparam int FIFO_DEPTH_DEF = 16;

   // Sticky error flag bit positions.
   localparam int ERR_W     = 3;
   localparam int ERR_OVF   = 0;  // cell arrived after the last map address was used
   localparam int ERR_UNEXP = 1;  // recursion result with no pending address, or FIFO overrun
   localparam int ERR_HAZ   = 2;  // frame_start while write-backs are still pending

   // Fixed-point scale of the recursion coefficient (coeff / 1000).
   localparam int RECUR_SCALE = 1000;

endpackage

// File: rtl/clut_addr_fifo.sv
// Synchronous show-ahead FIFO holding map addresses awaiting write-back.
module clut_addr_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign do_pop     = pop_i & ~empty_o;
   // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
   assign do_push    = push_i & (~full_o | do_pop);
   assign pop_data_o = mem_q[rd_ptr_q];

   // Storage write; contents are don't-care while the FIFO is empty.
   // NOTE: storage arrays carry no reset -- only pointers/count define validity.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointer and occupancy bookkeeping; reset flushes all pending entries.
   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/clut_map_rdwr_ctrl.sv
// Clutter-map RAM owner: reads y(n-1) for each cell, hands {x, y(n-1)} to the
// recursion unit, and writes the returned y(n) back to the same map address.
module clut_map_rdwr_ctrl
   import clut_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              map_init,
   input  logic              cell_vld,
   input  logic [DATA_W-1:0] cell_dat,
   output logic              radmap_rd_vld,
   output logic [DATA_W-1:0] radmap_rd_din0,
   output logic [DATA_W-1:0] radmap_rd_din2,
   input  logic              recur_valid,
   input  logic [DATA_W-1:0] recur_dat,
   output logic              clut_vld,
   output logic [DATA_W-1:0] clut_dat,
   output logic              busy,
   output logic [ERR_W-1:0]  err_flags
);

   localparam int MAP_DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   // Map storage and its registered read port.
   logic [DATA_W-1:0] map_ram [MAP_DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Frame / address state.
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              addr_done_q, addr_done_d;  // last address already used this frame
   logic              init_q, init_d;            // current frame initialises the map
   logic              first_q, first_d;          // no frame_start seen since reset

   // Read pipeline towards the recursion unit.
   logic              rd_vld_q;
   logic [DATA_W-1:0] x_q;
   logic [ADDR_W-1:0] pair_addr_q;

   // Write-back result and sticky errors.
   logic              clut_vld_q, clut_vld_d;
   logic [DATA_W-1:0] clut_dat_q, clut_dat_d;
   logic [ERR_W-1:0]  err_q, err_d;

   // Per-cycle decode.
   logic [ADDR_W-1:0] cur_addr;
   logic              cur_done;
   logic              cur_init;
   logic              cell_acc;
   logic              cell_drop;
   logic              rd_req;
   logic              init_wr;
   logic              wb_ok;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;

   // Pending write-back FIFO.
   logic [ADDR_W-1:0] fifo_head;
   logic              fifo_empty;
   logic              fifo_full;

   clut_addr_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_addr_fifo (
      .clk_i       (sys_clk),
      .rst_i       (rst),
      .push_i      (rd_vld_q),
      .push_data_i (pair_addr_q),
      .pop_i       (wb_ok),
      .pop_data_o  (fifo_head),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   assign wb_ok = recur_valid & ~fifo_empty;

   // Cell acceptance, address sequencing, RAM write arbitration and error detection.
   // NOTE: every signal assigned here gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      // A frame_start in the same cycle as a cell makes that cell address 0 of the new frame.
      cur_addr    = frame_start ? '0 : addr_q;
      cur_done    = frame_start ? 1'b0 : addr_done_q;
      cur_init    = frame_start ? (map_init | first_q) : init_q;

      cell_acc    = cell_vld & ~cur_done;
      cell_drop   = cell_vld & cur_done;
      rd_req      = cell_acc & ~cur_init;
      init_wr     = cell_acc & cur_init;

      addr_d      = cur_addr;
      addr_done_d = cur_done;
      if (cell_acc) begin
         if (cur_addr == ADDR_LAST) begin
            addr_done_d = 1'b1;  // saturate; later cells this frame are dropped
         end else begin
            addr_d = cur_addr + ADDR_W'(1);
         end
      end
      init_d  = cur_init;
      first_d = first_q & ~frame_start;

      // Single write port: a recursion write-back takes the port ahead of an
      // init-frame cell; the two only meet if an init frame is started while busy.
      ram_we    = 1'b0;
      ram_waddr = cur_addr;
      ram_wdata = cell_dat;
      if (wb_ok) begin
         ram_we    = 1'b1;
         ram_waddr = fifo_head;
         ram_wdata = recur_dat;
      end else if (init_wr) begin
         ram_we    = 1'b1;
      end
      clut_vld_d = ram_we;
      clut_dat_d = ram_we ? ram_wdata : clut_dat_q;

      err_d            = err_q;
      err_d[ERR_OVF]   = err_q[ERR_OVF] | cell_drop;
      err_d[ERR_UNEXP] = err_q[ERR_UNEXP] | (recur_valid & fifo_empty)
                       | (rd_vld_q & fifo_full & ~wb_ok);
      err_d[ERR_HAZ]   = err_q[ERR_HAZ] | (frame_start & ~fifo_empty);
   end

   // Map RAM write port; the array itself is never cleared.
   always_ff @(posedge sys_clk) begin
      if (ram_we) begin
         map_ram[ram_waddr] <= ram_wdata;
      end
   end

   // Control, read pipeline and output registers; reset discards any in-flight pair.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         addr_q      <= '0;
         addr_done_q <= 1'b0;
         init_q      <= 1'b1;
         first_q     <= 1'b1;
         rd_vld_q    <= 1'b0;
         x_q         <= '0;
         rd_data_q   <= '0;
         pair_addr_q <= '0;
         clut_vld_q  <= 1'b0;
         clut_dat_q  <= '0;
         err_q       <= '0;
      end else begin
         addr_q      <= addr_d;
         addr_done_q <= addr_done_d;
         init_q      <= init_d;
         first_q     <= first_d;
         rd_vld_q    <= rd_req;
         if (rd_req) begin
            x_q         <= cell_dat;
            rd_data_q   <= map_ram[cur_addr];
            pair_addr_q <= cur_addr;
         end
         clut_vld_q  <= clut_vld_d;
         clut_dat_q  <= clut_dat_d;
         err_q       <= err_d;
      end
   end

   assign radmap_rd_vld  = rd_vld_q;
   assign radmap_rd_din0 = x_q;
   assign radmap_rd_din2 = rd_data_q;
   assign clut_vld       = clut_vld_q;
   assign clut_dat       = clut_dat_q;
   assign busy           = ~fifo_empty;
   assign err_flags      = err_q;

endmodule

// File: tb/tb_clut_map_rdwr_ctrl.sv
// Bench for clut_map_rdwr_ctrl: wraps a 6-cycle first-order recursion unit
// (coefficient 300/1000) and checks the map controller against a map model.
module tb_clut_map_rdwr_ctrl;
   import clut_pkg::*;

   localparam int AW    = 12;
   localparam int DW    = 16;
   localparam int DEPTH = 1 << AW;
   localparam int COEFF = 300;
   localparam int LAT   = 6;

   logic          sys_clk;
   logic          rst;
   logic          frame_start;
   logic          map_init;
   logic          cell_vld;
   logic [DW-1:0] cell_dat;
   logic          radmap_rd_vld;
   logic [DW-1:0] radmap_rd_din0;
   logic [DW-1:0] radmap_rd_din2;
   logic          recur_valid;
   logic [DW-1:0] recur_dat;
   logic          clut_vld;
   logic [DW-1:0] clut_dat;
   logic          busy;
   logic [2:0]    err_flags;

   clut_map_rdwr_ctrl #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .FIFO_DEPTH (16)
   ) dut (
      .sys_clk        (sys_clk),
      .rst            (rst),
      .frame_start    (frame_start),
      .map_init       (map_init),
      .cell_vld       (cell_vld),
      .cell_dat       (cell_dat),
      .radmap_rd_vld  (radmap_rd_vld),
      .radmap_rd_din0 (radmap_rd_din0),
      .radmap_rd_din2 (radmap_rd_din2),
      .recur_valid    (recur_valid),
      .recur_dat      (recur_dat),
      .clut_vld       (clut_vld),
      .clut_dat       (clut_dat),
      .busy           (busy),
      .err_flags      (err_flags)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   function automatic logic [DW-1:0] recur_model(input logic [DW-1:0] x, input logic [DW-1:0] y);
      int r;
      r = (COEFF * int'(x) + (RECUR_SCALE - COEFF) * int'(y)) / RECUR_SCALE;
      return DW'(r);
   endfunction

   // Recursion unit: y(n) = (300*x + 700*y(n-1)) / 1000, six-cycle latency; not reset.
   logic [LAT-1:0] rv_pipe = '0;
   logic [DW-1:0]  ry_pipe [LAT];
   logic           force_recur;
   logic [DW-1:0]  force_dat;

   always @(posedge sys_clk) begin
      rv_pipe    <= {rv_pipe[LAT-2:0], radmap_rd_vld};
      ry_pipe[0] <= recur_model(radmap_rd_din0, radmap_rd_din2);
      for (int i = 1; i < LAT; i++) ry_pipe[i] <= ry_pipe[i-1];
   end

   assign recur_valid = rv_pipe[LAT-1] | force_recur;
   assign recur_dat   = force_recur ? force_dat : ry_pipe[LAT-1];

   // Scoreboard: expected pairs and map updates queued at drive time.
   typedef struct packed {
      logic [DW-1:0] x;
      logic [DW-1:0] y;
   } pair_t;

   pair_t         pair_q [$];
   logic [DW-1:0] clut_q [$];
   logic [DW-1:0] model_map [DEPTH];
   bit            sb_en      = 1'b0;
   bit            busy_watch = 1'b0;
   int            busy_hits  = 0;

   always @(negedge sys_clk) begin
      pair_t         p;
      logic [DW-1:0] e;
      if (sb_en) begin
         if (radmap_rd_vld) begin
            if (pair_q.size() == 0) begin
               check("sb_unexpected_pair", radmap_rd_vld, 1'b0);
            end else begin
               p = pair_q.pop_front();
               check("sb_din0", radmap_rd_din0, p.x);
               check("sb_din2", radmap_rd_din2, p.y);
            end
         end
         if (clut_vld) begin
            if (clut_q.size() == 0) begin
               check("sb_unexpected_clut", clut_vld, 1'b0);
            end else begin
               e = clut_q.pop_front();
               check("sb_clut_dat", clut_dat, e);
            end
         end
      end
      if (busy_watch && busy) busy_hits++;
   end

   typedef struct {
      logic          new_frame;
      logic          map_init;
      logic [DW-1:0] x;
      logic          exp_pair;
      logic [DW-1:0] exp_din2;
      logic [DW-1:0] exp_clut;
   } vec_t;

   vec_t          vecs [6];
   logic [DW-1:0] x;
   logic [DW-1:0] y;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 16'd1000,  1'b0, 16'd0,    16'd1000};
      vecs[1] = '{1'b0, 1'b0, 16'd2000,  1'b0, 16'd0,    16'd2000};
      vecs[2] = '{1'b0, 1'b0, 16'd0,     1'b0, 16'd0,    16'd0};
      vecs[3] = '{1'b0, 1'b0, 16'd65535, 1'b0, 16'd0,    16'd65535};
      vecs[4] = '{1'b1, 1'b0, 16'd2000,  1'b1, 16'd1000, 16'd1300};
      vecs[5] = '{1'b1, 1'b0, 16'd2000,  1'b1, 16'd1300, 16'd1510};

      rst = 1'b1; frame_start = 1'b0; map_init = 1'b0; cell_vld = 1'b0; cell_dat = '0;
      force_recur = 1'b0; force_dat = '0;
      repeat (3) tick();
      check("rst_rd_vld", radmap_rd_vld, 1'b0);
      check("rst_din0", radmap_rd_din0, 16'd0);
      check("rst_din2", radmap_rd_din2, 16'd0);
      check("rst_clut_vld", clut_vld, 1'b0);
      check("rst_clut_dat", clut_dat, 16'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err_flags, 3'b000);
      rst = 1'b0;
      tick();

      // Table: first frame after reset initialises (map_init=0), then two recursive frames.
      for (int i = 0; i < 6; i++) begin
         frame_start = vecs[i].new_frame;
         map_init    = vecs[i].map_init;
         cell_vld    = 1'b1;
         cell_dat    = vecs[i].x;
         tick();
         frame_start = 1'b0; cell_vld = 1'b0; cell_dat = '0;
         check("tbl_rd_vld_t1", radmap_rd_vld, vecs[i].exp_pair);
         if (vecs[i].exp_pair) begin
            check("tbl_din0", radmap_rd_din0, vecs[i].x);
            check("tbl_din2", radmap_rd_din2, vecs[i].exp_din2);
            check("tbl_clut_vld_t1", clut_vld, 1'b0);
            tick();
            check("tbl_busy_t2", busy, 1'b1);
            check("tbl_rd_vld_t2", radmap_rd_vld, 1'b0);
            check("tbl_din0_hold", radmap_rd_din0, vecs[i].x);
            repeat (5) tick();
            check("tbl_clut_vld_t7", clut_vld, 1'b0);
            tick();
            check("tbl_clut_vld_t8", clut_vld, 1'b1);
            check("tbl_clut_dat_t8", clut_dat, vecs[i].exp_clut);
            tick();
            check("tbl_busy_t9", busy, 1'b0);
            check("tbl_clut_vld_t9", clut_vld, 1'b0);
         end else begin
            check("tbl_init_clut_vld", clut_vld, 1'b1);
            check("tbl_init_clut_dat", clut_dat, vecs[i].exp_clut);
            check("tbl_init_busy", busy, 1'b0);
            tick();
            check("tbl_init_clut_vld_t2", clut_vld, 1'b0);
            check("tbl_init_clut_hold", clut_dat, vecs[i].exp_clut);
         end
      end
      check("tbl_err", err_flags, 3'b000);

      // Full init frame plus one extra cell: every address written in order, extra dropped.
      pair_q.delete(); clut_q.delete();
      sb_en = 1'b1; busy_watch = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         frame_start = (i == 0);
         map_init    = (i == 0);
         cell_vld    = 1'b1;
         x           = 16'($urandom);
         cell_dat    = x;
         if (i < DEPTH) begin
            clut_q.push_back(x);
            model_map[i] = x;
         end
         tick();
      end
      frame_start = 1'b0; map_init = 1'b0; cell_vld = 1'b0; cell_dat = '0;
      repeat (4) tick();
      busy_watch = 1'b0;
      check("ovf_init_clut_left", clut_q.size(), 0);
      check("ovf_init_busy_hits", busy_hits, 0);
      check("ovf_init_err", err_flags, 3'b001);

      // Full recursive frame plus one extra cell; busy falls 7 cycles after the last push.
      for (int i = 0; i <= DEPTH; i++) begin
         frame_start = (i == 0);
         cell_vld    = 1'b1;
         x           = 16'($urandom);
         cell_dat    = x;
         if (i < DEPTH) begin
            pair_q.push_back({x, model_map[i]});
            y = recur_model(x, model_map[i]);
            clut_q.push_back(y);
            model_map[i] = y;
         end
         tick();
      end
      frame_start = 1'b0; cell_vld = 1'b0; cell_dat = '0;
      repeat (5) tick();
      check("ovf_busy_before_fall", busy, 1'b1);
      tick();
      check("ovf_busy_fall", busy, 1'b0);
      repeat (3) tick();
      check("ovf_pair_left", pair_q.size(), 0);
      check("ovf_clut_left", clut_q.size(), 0);
      check("ovf_err", err_flags, 3'b001);

      // Unexpected recursion strobe with nothing pending.
      tick();
      force_recur = 1'b1; force_dat = 16'hBEEF;
      tick();
      force_recur = 1'b0;
      check("unexp_clut_vld", clut_vld, 1'b0);
      check("unexp_err", err_flags, 3'b011);

      // frame_start 2 cycles after the last cell while write-backs are pending.
      for (int i = 0; i < 3; i++) begin
         frame_start = (i == 0);
         cell_vld    = 1'b1;
         x           = 16'($urandom);
         cell_dat    = x;
         pair_q.push_back({x, model_map[i]});
         y = recur_model(x, model_map[i]);
         clut_q.push_back(y);
         model_map[i] = y;
         tick();
      end
      cell_vld = 1'b0; cell_dat = '0;
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("haz_err", err_flags, 3'b111);
      repeat (10) tick();
      check("haz_clut_left", clut_q.size(), 0);
      // Re-read the same addresses: din2 must hold the values written back after the hazard.
      for (int i = 0; i < 3; i++) begin
         frame_start = (i == 0);
         cell_vld    = 1'b1;
         x           = 16'($urandom);
         cell_dat    = x;
         pair_q.push_back({x, model_map[i]});
         y = recur_model(x, model_map[i]);
         clut_q.push_back(y);
         model_map[i] = y;
         tick();
      end
      frame_start = 1'b0; cell_vld = 1'b0; cell_dat = '0;
      repeat (12) tick();
      check("haz_verify_pair_left", pair_q.size(), 0);
      check("haz_verify_clut_left", clut_q.size(), 0);

      // Reset with three write-backs pending; late results must be discarded.
      sb_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         frame_start = (i == 0);
         cell_vld    = 1'b1;
         cell_dat    = 16'd5000 + 16'(i);
         tick();
      end
      frame_start = 1'b0; cell_vld = 1'b0; cell_dat = '0;
      tick();
      check("rstmid_busy_before", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid_rd_vld", radmap_rd_vld, 1'b0);
      check("rstmid_din0", radmap_rd_din0, 16'd0);
      check("rstmid_din2", radmap_rd_din2, 16'd0);
      check("rstmid_clut_vld", clut_vld, 1'b0);
      check("rstmid_clut_dat", clut_dat, 16'd0);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_err", err_flags, 3'b000);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("rstmid_no_clut", clut_vld, 1'b0);
      end
      check("rstmid_late_err", err_flags, 3'b010);
      check("rstmid_late_busy", busy, 1'b0);

      // Next frame initialises even with map_init=0.
      frame_start = 1'b1; map_init = 1'b0; cell_vld = 1'b1; cell_dat = 16'd777;
      tick();
      frame_start = 1'b0; cell_vld = 1'b0; cell_dat = '0;
      check("postrst_rd_vld", radmap_rd_vld, 1'b0);
      check("postrst_clut_vld", clut_vld, 1'b1);
      check("postrst_clut_dat", clut_dat, 16'd777);
      check("postrst_busy", busy, 1'b0);
      tick();
      frame_start = 1'b1; cell_vld = 1'b1; cell_dat = 16'd1000;
      tick();
      frame_start = 1'b0; cell_vld = 1'b0; cell_dat = '0;
      check("postrst_next_rd_vld", radmap_rd_vld, 1'b1);
      check("postrst_next_din2", radmap_rd_din2, 16'd777);
      repeat (10) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clut_map_rdwr_ctrl.md
Name: clut_map_rdwr_ctrl

Overview:
- Owns the clutter-map RAM and drives the first-order recursion unit.
- Per incoming range-Doppler cell x(n), reads the stored map value y(n-1) and issues the pair on radmap_rd_vld/din0/din2.
- Takes back recur_valid/recur_dat and writes y(n) to the same map address.
- Sits between the CFAR/magnitude stream and the recursion unit; also forwards each updated map value to detection.

Parameters:
- ADDR_W, 12, log2 of cells per frame; map depth is 2^ADDR_W.
- DATA_W, 16, width of cell and map data.
- FIFO_DEPTH, 16, pending write-back address slots; must be at least recursion latency + 2.

Ports:
- sys_clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- frame_start  in  1  one-cycle pulse marking the start of a frame.
- map_init  in  1  level, sampled at frame_start; 1 = this frame initialises the map.
- cell_vld  in  1  input cell strobe; back-to-back allowed.
- cell_dat  in  DATA_W  cell magnitude x(n).
- radmap_rd_vld  out  1  pair valid to recursion unit.
- radmap_rd_din0  out  DATA_W  x(n).
- radmap_rd_din2  out  DATA_W  y(n-1) from map.
- recur_valid  in  1  recursion result strobe.
- recur_dat  in  DATA_W  y(n).
- clut_vld  out  1  updated map value strobe.
- clut_dat  out  DATA_W  value just written to map.
- busy  out  1  write-backs pending (FIFO non-empty).
- err_flags  out  3  sticky: [0] cell overflow, [1] unexpected recur_valid, [2] frame_start while busy.

Behaviour:
- Reset: all outputs 0; cell address 0; FIFO empty; init_frame = 1, so the first frame after reset always initialises the map. RAM contents are not cleared.
- Map RAM: simple dual-port, 2^ADDR_W x DATA_W, 1-cycle read latency, write takes effect at the next edge. Read and write of the same address in one cycle returns old data; this cannot occur in a legal frame.
- frame_start: cell address <= 0; init_frame <= map_init OR first-since-reset.
  - If frame_start coincides with cell_vld, that cell is address 0 of the new frame.
  - If busy=1 at frame_start, set err_flags[2]; processing continues.
- Normal frame, cell_vld at cycle t:
  - t: RAM read of the current address; x registered.
  - t+1: radmap_rd_vld=1, din0=x, din2=RAM data; address pushed into FIFO; cell address increments.
- Write-back: on recur_valid, pop FIFO address and write recur_dat to RAM in that cycle. clut_vld=1 and clut_dat=recur_dat on the next cycle. With the 6-cycle recursion unit, clut_vld occurs at t+8.
- Init frame, cell_vld at t:
  - No radmap_rd_vld; nothing pushed into FIFO.
  - RAM[addr] <= cell_dat at t.
  - t+1: clut_vld=1, clut_dat=cell_dat.
- Outputs hold their last value when not valid. Only the strobes return to 0.
- Overflow: after address 2^ADDR_W-1 has been used, further cell_vld in the same frame are dropped, err_flags[0] is set, and the address saturates.
- recur_valid with FIFO empty: write ignored, err_flags[1] set, no clut_vld.
- Simultaneous push and pop in one cycle: both performed; occupancy unchanged.
- FIFO full on push: cannot occur when FIFO_DEPTH ≥ latency + 2 (one cell per cycle). If it does occur, the push is dropped and err_flags[1] is set.
- rst mid-frame: FIFO flushed, in-flight results discarded, init_frame=1. Late recur_valid after reset sets err_flags[1].
- err_flags clear only on rst.

Decomposition:
- Shared package clut_pkg: DATA_W/ADDR_W defaults, error bit indices (ERR_OVF=0, ERR_UNEXP=1, ERR_HAZ=2), and the recursion coefficient scale constant 1000.
- One sub-module: clut_addr_fifo, a synchronous FIFO of ADDR_W-wide addresses with push/pop/empty/full.
- RAM is inferred inline.

Test Plan:
- Bench wraps the recursion unit (recur_coeff=300).
- After rst, frame_start with map_init=0, cells addr0..3 = 1000,2000,0,65535 -> no radmap_rd_vld; clut_dat = 1000,2000,0,65535 at t+1 each; busy stays 0.
- Next frame, map_init=0, cell addr0 x=2000 -> radmap_rd_vld at t+1 with din0=2000, din2=1000; recur_dat=1300; clut_vld at t+8 with clut_dat=1300. A third frame with x=2000 reads din2=1300.
- 4096 back-to-back cells, then one extra cell_vld -> all 4096 written in order, extra cell dropped, err_flags=3'b001, busy falls 0 exactly 7 cycles after the last push.
- Stub forces recur_valid with FIFO empty -> no RAM write and no clut_vld; err_flags[1]=1.
- frame_start 2 cycles after the last cell of a frame -> err_flags[2]=1; pending write-backs still land at their original addresses.
- rst asserted with 3 write-backs pending -> outputs 0 next cycle, busy=0; the next frame behaves as an init frame even though map_init=0.
